wb_regfile: RTL and testbench

Writeback-stage consumer of the MEM/WB pipeline outputs in the pipelined RISC-V core. It selects the writeback value from the WB-stage fields, commits it to a 32 x 32-bit integer register file, and serves the two ID-stage read ports with same-cycle write-through bypass. It also exports the committed writeback value for EX-stage forwarding and keeps a free-running count of committed register writes.

---
 rtl/wb_regfile.sv | 101 ++++++++++
 tb/tb_wb_regfile.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage of the pipelined RISC-V core.
// It selects the writeback value from the WB-stage fields and commits it to a
// 32 x 32-bit integer register file. It serves two ID-stage read ports, and a
// write in the same cycle is bypassed straight through to them. It also counts
// committed writes.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-low reset
//   REGWRITE_WB         register write enable
//   DATATOREGSEL_WB     writeback source select
//   PC_WB, IMM_WB       WB-stage PC and immediate
//   ALUOUT_WB           ALU result
//   MEMDATA_WB          extended load data
//   RD_WB               destination register
//   RS1_ID, RS2_ID      read port addresses
//   RS1DATA_ID/RS2DATA_ID  read port data (combinational, with bypass)
//   WBDATA_WB           selected writeback value (combinational)
//   WBVALID_WB          a write commits this cycle (combinational)
//   WRCOUNT             registered count of committed writes
module wb_regfile #(
  parameter logic [31:0] SP_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        REGWRITE_WB,
  input  logic [2:0]  DATATOREGSEL_WB,
  input  logic [31:0] PC_WB,
  input  logic [31:0] IMM_WB,
  input  logic [31:0] ALUOUT_WB,
  input  logic [31:0] MEMDATA_WB,
  input  logic [4:0]  RD_WB,
  input  logic [4:0]  RS1_ID,
  input  logic [4:0]  RS2_ID,
  output logic [31:0] RS1DATA_ID,
  output logic [31:0] RS2DATA_ID,
  output logic [31:0] WBDATA_WB,
  output logic        WBVALID_WB,
  output logic [31:0] WRCOUNT
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;

  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] wrcount_q;

  // Writeback source select; the additions wrap modulo 2^32.
  always_comb begin
    WBDATA_WB = '0;
    case (DATATOREGSEL_WB)
      3'b000:  WBDATA_WB = ALUOUT_WB;
      3'b001:  WBDATA_WB = MEMDATA_WB;
      3'b010:  WBDATA_WB = PC_WB + XLEN'(4);
      3'b011:  WBDATA_WB = IMM_WB;
      3'b100:  WBDATA_WB = PC_WB + IMM_WB;
      default: WBDATA_WB = '0;
    endcase
  end

  // Holding rst low kills the commit, and with it the bypass. x0 never commits.
  assign WBVALID_WB = rst & REGWRITE_WB & (RD_WB != AW'(0));

  // Read ports: x0 reads as zero first, then the bypass, then the array.
  always_comb begin
    RS1DATA_ID = regs[RS1_ID];
    if (RS1_ID == AW'(0))
      RS1DATA_ID = '0;
    else if (WBVALID_WB && (RD_WB == RS1_ID))
      RS1DATA_ID = WBDATA_WB;
  end

  always_comb begin
    RS2DATA_ID = regs[RS2_ID];
    if (RS2_ID == AW'(0))
      RS2DATA_ID = '0;
    else if (WBVALID_WB && (RD_WB == RS2_ID))
      RS2DATA_ID = WBDATA_WB;
  end

  // Register array. On reset, sp is loaded with SP_INIT and every other entry is cleared.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == 2) ? SP_INIT : '0;
      end
    end else if (WBVALID_WB) begin
      regs[RD_WB] <= WBDATA_WB;
    end
  end

  // Free-running count of committed writes. It wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst)
      wrcount_q <= '0;
    else if (WBVALID_WB)
      wrcount_q <= wrcount_q + XLEN'(1);
  end

  assign WRCOUNT = wrcount_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile. A behavioural model of the register
// file, written from the architectural rules, runs alongside the DUT. The bench
// combines directed scenarios with randomized traffic.
module tb_wb_regfile;

  localparam logic [31:0] SP_VAL = 32'h0000_8000;

  logic        clk = 1'b0;
  logic        rst;
  logic        regwrite_wb;
  logic [2:0]  sel_wb;
  logic [31:0] pc_wb, imm_wb, aluout_wb, memdata_wb;
  logic [4:0]  rd_wb, rs1_id, rs2_id;
  logic [31:0] rs1data, rs2data, wbdata, wrcount;
  logic        wbvalid;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mregs [32];
  logic [31:0] mcount;

  wb_regfile #(.SP_INIT(SP_VAL)) dut (
    .clk(clk), .rst(rst),
    .REGWRITE_WB(regwrite_wb), .DATATOREGSEL_WB(sel_wb),
    .PC_WB(pc_wb), .IMM_WB(imm_wb), .ALUOUT_WB(aluout_wb),
    .MEMDATA_WB(memdata_wb), .RD_WB(rd_wb),
    .RS1_ID(rs1_id), .RS2_ID(rs2_id),
    .RS1DATA_ID(rs1data), .RS2DATA_ID(rs2data),
    .WBDATA_WB(wbdata), .WBVALID_WB(wbvalid), .WRCOUNT(wrcount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_wb();
    case (sel_wb)
      3'd0:    return aluout_wb;
      3'd1:    return memdata_wb;
      3'd2:    return pc_wb + 32'd4;
      3'd3:    return imm_wb;
      3'd4:    return pc_wb + imm_wb;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit exp_valid();
    return (rst === 1'b1) && (regwrite_wb === 1'b1) && (rd_wb != 5'd0);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (exp_valid() && rd_wb == a) return exp_wb();
    return mregs[a];
  endfunction

  function automatic void model_reset();
    foreach (mregs[i]) mregs[i] = 32'h0;
    mregs[2] = SP_VAL;
    mcount = 32'h0;
  endfunction

  // Checks the combinational outputs against the model, then clocks one edge.
  task automatic cycle();
    logic [31:0] ew;
    bit ev;
    #1;
    ew = exp_wb();
    ev = exp_valid();
    check("wbdata", wbdata, ew);
    check("wbvalid", {31'b0, wbvalid}, {31'b0, ev});
    check("rs1data", rs1data, exp_read(rs1_id));
    check("rs2data", rs2data, exp_read(rs2_id));
    check("wrcount", wrcount, mcount);
    @(posedge clk);
    if (!rst) model_reset();
    else if (ev) begin
      mregs[rd_wb] = ew;
      mcount = mcount + 32'd1;
    end
    #1;
  endtask

  task automatic set_write(input logic we, input logic [4:0] rd, input logic [2:0] s,
                           input logic [31:0] alu);
    regwrite_wb = we; rd_wb = rd; sel_wb = s; aluout_wb = alu;
  endtask

  logic [31:0] sweep_exp [6];
  logic [2:0]  sweep_sel [6];
  logic [31:0] cnt_before;

  initial begin
    rst = 1'b0; regwrite_wb = 1'b1; sel_wb = 3'd0;
    pc_wb = 32'h0; imm_wb = 32'h0; aluout_wb = 32'h1234; memdata_wb = 32'h0;
    rd_wb = 5'd2; rs1_id = 5'd2; rs2_id = 5'd5;

    // Reset for two edges. A write to sp is presented throughout and must be ignored.
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    check("rst_rs1_sp", rs1data, SP_VAL);
    check("rst_rs2_x5", rs2data, 32'h0);
    check("rst_wrcount", wrcount, 32'h0);
    check("rst_wbvalid", {31'b0, wbvalid}, 32'h0);
    rst = 1'b1;

    // Source select sweep into x7.
    pc_wb = 32'h100; imm_wb = 32'h20; aluout_wb = 32'hA5; memdata_wb = 32'h5A;
    rd_wb = 5'd7; regwrite_wb = 1'b1; rs1_id = 5'd7; rs2_id = 5'd7;
    sweep_sel = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    sweep_exp = '{32'hA5, 32'h5A, 32'h104, 32'h20, 32'h120, 32'h0};
    for (int i = 0; i < 6; i++) begin
      sel_wb = sweep_sel[i];
      #1 check("sel_wbdata", wbdata, sweep_exp[i]);
      cycle();
      regwrite_wb = 1'b0;
      #1 check("sel_x7", rs1data, sweep_exp[i]);
      regwrite_wb = 1'b1;
    end

    // Bypass on both ports.
    rs1_id = 5'd9; rs2_id = 5'd9;
    set_write(1'b1, 5'd9, 3'd0, 32'hDEAD_BEEF);
    #1 check("byp_rs1", rs1data, 32'hDEAD_BEEF);
    check("byp_rs2", rs2data, 32'hDEAD_BEEF);
    cycle();
    regwrite_wb = 1'b0;
    #1 check("byp_x9_held", rs1data, 32'hDEAD_BEEF);

    // x0 protection.
    cnt_before = mcount;
    rs1_id = 5'd0;
    set_write(1'b1, 5'd0, 3'd0, 32'hFFFF_FFFF);
    #1 check("x0_wbvalid", {31'b0, wbvalid}, 32'h0);
    check("x0_read", rs1data, 32'h0);
    cycle();
    regwrite_wb = 1'b0;
    #1 check("x0_wrcount", wrcount, cnt_before);
    check("x0_after", rs1data, 32'h0);

    // Reset in the middle of traffic.
    rs1_id = 5'd3; rs2_id = 5'd4;
    set_write(1'b1, 5'd3, 3'd0, 32'h11);
    cycle();
    set_write(1'b1, 5'd4, 3'd0, 32'h22);
    rst = 1'b0;
    cycle();
    rst = 1'b1; regwrite_wb = 1'b0;
    #1 check("mid_x3", rs1data, 32'h0);
    check("mid_x4", rs2data, 32'h0);
    check("mid_wrcount", wrcount, 32'h0);

    // Counter: five commits and two non-writes.
    for (int i = 0; i < 7; i++) begin
      set_write((i % 3) != 1, 5'(10 + i), 3'd0, 32'(i));
      cycle();
    end
    regwrite_wb = 1'b0;
    #1 check("cnt_five", wrcount, 32'd5);

    // Randomized traffic, with occasional reset pulses.
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(0, 39) != 0);
      regwrite_wb = $urandom_range(0, 3) != 0;
      sel_wb      = 3'($urandom_range(0, 7));
      pc_wb       = $urandom;
      imm_wb      = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
      aluout_wb   = $urandom;
      memdata_wb  = $urandom;
      rd_wb       = 5'($urandom_range(0, 31));
      rs1_id      = ($urandom_range(0, 2) == 0) ? rd_wb : 5'($urandom_range(0, 31));
      rs2_id      = ($urandom_range(0, 2) == 0) ? rd_wb : 5'($urandom_range(0, 31));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
